// File: rtl/game_state_sync.sv
// Double-buffers game-state packets and commits them atomically at the start of vertical blanking.
// A capture lands one cycle after data_ready_i and a commit one cycle after frame_start_i. There is no backpressure; overwritten uncommitted packets are counted.
module game_state_sync #(
   parameter int  NUM_COORDS   = 4,
   parameter int  COORD_W      = 10,
   parameter int  COORD_MAX    = 799,
   parameter int  NUM_SCORES   = 2,
   parameter int  STALE_FRAMES = 60,
   localparam int NUM_BYTES    = 2*NUM_COORDS + NUM_SCORES
) (
   input  logic               sys_clk_i,
   input  logic               sys_rst_i,
   input  logic               data_ready_i,
   input  logic [7:0]         data_in [NUM_BYTES],
   input  logic               frame_start_i,
   output logic [COORD_W-1:0] coord_o [NUM_COORDS],
   output logic [7:0]         score_o [NUM_SCORES],
   output logic               frame_update_o,
   output logic               pending_o,
   output logic               stale_o,
   output logic [7:0]         drop_cnt_o,
   output logic               clamp_err_o
);

   localparam logic [COORD_W-1:0] CMAX      = COORD_W'(COORD_MAX);
   localparam logic [7:0]         STALE_LIM = 8'(STALE_FRAMES);

   typedef enum logic {EMPTY, PENDING} state_t;

   state_t             state_q, state_d;
   logic               commit, overrun;

   logic [COORD_W-1:0] dec_coord [NUM_COORDS];
   logic [7:0]         dec_score [NUM_SCORES];
   logic               dec_clamp;

   logic [COORD_W-1:0] shadow_coord_q [NUM_COORDS];
   logic [7:0]         shadow_score_q [NUM_SCORES];
   logic [COORD_W-1:0] coord_q [NUM_COORDS];
   logic [7:0]         score_q [NUM_SCORES];
   logic               upd_q;
   logic               clamp_q, clamp_d;
   logic [7:0]         drop_q, drop_d;
   logic [7:0]         stale_q, stale_d;

   // Low byte first; high-byte bits above COORD_W are dropped by the cast.
   always_comb begin
      dec_clamp = 1'b0;
      for (int i = 0; i < NUM_COORDS; i++) begin
         dec_coord[i] = COORD_W'({data_in[2*i+1], data_in[2*i]});
         if (dec_coord[i] > CMAX) begin
            dec_coord[i] = CMAX;
            dec_clamp    = 1'b1;
         end
      end
      for (int j = 0; j < NUM_SCORES; j++) begin
         dec_score[j] = data_in[2*NUM_COORDS+j];
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) state_q <= EMPTY;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      overrun = 1'b0;
      case (state_q)
         EMPTY: begin
            if (data_ready_i) state_d = PENDING;
         end
         PENDING: begin
            commit  = frame_start_i;
            overrun = data_ready_i && !frame_start_i;
            if (frame_start_i && !data_ready_i) state_d = EMPTY;
         end
      endcase
   end

   always_comb begin
      drop_d  = drop_q;
      stale_d = stale_q;
      clamp_d = clamp_q | (data_ready_i & dec_clamp);
      if (overrun && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      if (commit) stale_d = 8'd0;
      else if (frame_start_i && stale_q != STALE_LIM) stale_d = stale_q + 8'd1;
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         for (int i = 0; i < NUM_COORDS; i++) begin
            shadow_coord_q[i] <= '0;
            coord_q[i]        <= '0;
         end
         for (int j = 0; j < NUM_SCORES; j++) begin
            shadow_score_q[j] <= '0;
            score_q[j]        <= '0;
         end
         upd_q   <= 1'b0;
         drop_q  <= 8'd0;
         stale_q <= 8'd0;
         clamp_q <= 1'b0;
      end else begin
         // Commit reads the old shadow in the same cycle a new packet may overwrite it.
         if (commit) begin
            for (int i = 0; i < NUM_COORDS; i++) coord_q[i] <= shadow_coord_q[i];
            for (int j = 0; j < NUM_SCORES; j++) score_q[j] <= shadow_score_q[j];
         end
         if (data_ready_i) begin
            for (int i = 0; i < NUM_COORDS; i++) shadow_coord_q[i] <= dec_coord[i];
            for (int j = 0; j < NUM_SCORES; j++) shadow_score_q[j] <= dec_score[j];
         end
         upd_q   <= commit;
         drop_q  <= drop_d;
         stale_q <= stale_d;
         clamp_q <= clamp_d;
      end
   end

   assign coord_o        = coord_q;
   assign score_o        = score_q;
   assign frame_update_o = upd_q;
   assign pending_o      = (state_q == PENDING);
   assign stale_o        = (stale_q == STALE_LIM);
   assign drop_cnt_o     = drop_q;
   assign clamp_err_o    = clamp_q;

endmodule

// File: tb/tb_game_state_sync.sv
// Bench for game_state_sync: packet-level reference model checked every cycle plus directed literal expectations.
module tb_game_state_sync;

   localparam int NC = 4, NS = 2, NB = 10, CW = 10, CMAX = 799, STALE = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, dr, fs;
   logic [7:0]    data_in [NB];
   logic [CW-1:0] coord_o [NC];
   logic [7:0]    score_o [NS];
   logic          upd, pend, stale, clamp;
   logic [7:0]    drop;

   game_state_sync #(.STALE_FRAMES(STALE)) dut (
      .sys_clk_i      (clk),
      .sys_rst_i      (rst),
      .data_ready_i   (dr),
      .data_in        (data_in),
      .frame_start_i  (fs),
      .coord_o        (coord_o),
      .score_o        (score_o),
      .frame_update_o (upd),
      .pending_o      (pend),
      .stale_o        (stale),
      .drop_cnt_o     (drop),
      .clamp_err_o    (clamp)
   );

   int n_chk = 0, n_pass = 0;

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: what a viewer should see after each clock, in plain integers.
   int  m_c [NC], m_s [NS], m_sc [NC], m_ss [NS];
   int  m_drop, m_stale;
   bit  m_pend, m_upd, m_clamp, m_commit, cmp_en = 1'b0;
   int  raw;

   always @(posedge clk) begin
      if (rst) begin
         foreach (m_c[i])  begin m_c[i] = 0; m_sc[i] = 0; end
         foreach (m_s[j])  begin m_s[j] = 0; m_ss[j] = 0; end
         m_drop = 0; m_stale = 0; m_pend = 0; m_upd = 0; m_clamp = 0;
         cmp_en = 1'b1;
      end else begin
         m_commit = m_pend && fs;
         m_upd    = m_commit;
         if (m_commit) begin
            m_c     = m_sc;
            m_s     = m_ss;
            m_stale = 0;
         end else if (fs) begin
            m_stale = (m_stale + 1 > STALE) ? STALE : m_stale + 1;
         end
         if (dr) begin
            if (m_pend && !fs) m_drop = (m_drop + 1 > 255) ? 255 : m_drop + 1;
            for (int i = 0; i < NC; i++) begin
               raw = (int'(data_in[2*i+1]) * 256 + int'(data_in[2*i])) % (1 << CW);
               if (raw > CMAX) begin
                  raw     = CMAX;
                  m_clamp = 1'b1;
               end
               m_sc[i] = raw;
            end
            for (int j = 0; j < NS; j++) m_ss[j] = int'(data_in[2*NC+j]);
            m_pend = 1'b1;
         end else if (fs) begin
            m_pend = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         for (int i = 0; i < NC; i++) check($sformatf("model coord_o[%0d]", i), int'(coord_o[i]), m_c[i]);
         for (int j = 0; j < NS; j++) check($sformatf("model score_o[%0d]", j), int'(score_o[j]), m_s[j]);
         check("model frame_update_o", int'(upd), int'(m_upd));
         check("model pending_o", int'(pend), int'(m_pend));
         check("model stale_o", int'(stale), int'(m_stale == STALE));
         check("model drop_cnt_o", int'(drop), m_drop);
         check("model clamp_err_o", int'(clamp), int'(m_clamp));
      end
   end

   task automatic step(bit d, bit f, bit r);
      dr = d; fs = f; rst = r;
      @(negedge clk);
      dr = 1'b0; fs = 1'b0; rst = 1'b0;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_pkt(logic [79:0] p);
      for (int k = 0; k < NB; k++) data_in[k] = p[79-8*k -: 8];
   endtask

   initial begin
      rst = 1'b1; dr = 1'b0; fs = 1'b0;
      set_pkt(80'h0);
      @(negedge clk);
      step(1'b0, 1'b0, 1'b1);
      check("reset coord_o[0]", int'(coord_o[0]), 0);
      check("reset pending_o", int'(pend), 0);
      check("reset drop_cnt_o", int'(drop), 0);
      check("reset stale_o", int'(stale), 0);
      check("reset clamp_err_o", int'(clamp), 0);

      // Basic commit
      set_pkt(80'h2001_4000_1000_8000_0305);
      step(1'b1, 1'b0, 1'b0);
      check("basic pending after capture", int'(pend), 1);
      idle(4);
      check("basic no early commit", int'(coord_o[0]), 0);
      step(1'b0, 1'b1, 1'b0);
      check("basic coord0", int'(coord_o[0]), 288);
      check("basic coord1", int'(coord_o[1]), 64);
      check("basic coord2", int'(coord_o[2]), 16);
      check("basic coord3", int'(coord_o[3]), 128);
      check("basic score0", int'(score_o[0]), 3);
      check("basic score1", int'(score_o[1]), 5);
      check("basic frame_update", int'(upd), 1);
      check("basic pending cleared", int'(pend), 0);
      idle(1);
      check("basic update one cycle", int'(upd), 0);

      // Clamp, sticky across a clean packet
      set_pkt(80'hFF03_0000_0000_0000_0000);
      step(1'b1, 1'b0, 1'b0);
      check("clamp flag at capture", int'(clamp), 1);
      step(1'b0, 1'b1, 1'b0);
      check("clamp coord0", int'(coord_o[0]), 799);
      set_pkt(80'h2001_4000_1000_8000_0305);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("clamp clean coord0", int'(coord_o[0]), 288);
      check("clamp sticky", int'(clamp), 1);

      // Overrun
      set_pkt(80'h0100_0000_0000_0000_0000); step(1'b1, 1'b0, 1'b0);
      set_pkt(80'h0200_0000_0000_0000_0000); step(1'b1, 1'b0, 1'b0);
      set_pkt(80'h0300_0000_0000_0000_0000); step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("overrun drop_cnt", int'(drop), 2);
      check("overrun third packet", int'(coord_o[0]), 3);
      for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0);
      check("overrun saturate", int'(drop), 255);
      step(1'b0, 1'b1, 1'b0);

      // Simultaneous capture and commit
      step(1'b0, 1'b0, 1'b1);
      check("reset drop cleared", int'(drop), 0);
      set_pkt(80'h0A00_0000_0000_0000_0000); step(1'b1, 1'b0, 1'b0);
      set_pkt(80'h0B00_0000_0000_0000_0000); step(1'b1, 1'b1, 1'b0);
      check("simul A visible", int'(coord_o[0]), 10);
      check("simul update", int'(upd), 1);
      check("simul pending", int'(pend), 1);
      step(1'b0, 1'b1, 1'b0);
      check("simul B visible", int'(coord_o[0]), 11);
      check("simul drop", int'(drop), 0);

      // Stale
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("stale after two frames", int'(stale), 0);
      step(1'b0, 1'b1, 1'b0);
      check("stale after three frames", int'(stale), 1);
      step(1'b0, 1'b1, 1'b0);
      check("stale held", int'(stale), 1);
      set_pkt(80'h2001_4000_1000_8000_0305);
      step(1'b1, 1'b0, 1'b0);
      check("stale while pending", int'(stale), 1);
      step(1'b0, 1'b1, 1'b0);
      check("stale cleared on commit", int'(stale), 0);
      check("stale commit update", int'(upd), 1);

      // Reset while a packet is pending
      set_pkt(80'h0C00_0000_0000_0000_0000);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("rst coord0", int'(coord_o[0]), 0);
      check("rst no update", int'(upd), 0);
      check("rst pending", int'(pend), 0);
      step(1'b0, 1'b1, 1'b0);
      check("rst discard update", int'(upd), 0);
      check("rst discard coord0", int'(coord_o[0]), 0);

      // Clamp boundaries and ignored high bits
      set_pkt(80'h1F03_0000_0000_0000_0000);
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
      check("bound 799 coord0", int'(coord_o[0]), 799);
      check("bound 799 no clamp", int'(clamp), 0);
      set_pkt(80'h10FC_0000_0000_0000_0000);
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
      check("high bits ignored", int'(coord_o[0]), 16);
      check("high bits no clamp", int'(clamp), 0);
      set_pkt(80'h2003_0000_0000_0000_0000);
      step(1'b1, 1'b0, 1'b0);
      check("bound 800 clamp", int'(clamp), 1);
      step(1'b0, 1'b1, 1'b0);
      check("bound 800 coord0", int'(coord_o[0]), 799);

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/game_state_sync.md
GAME_STATE_SYNC -- requirements
Module: game_state_sync

Interface
REQ-001 The module SHALL have parameter NUM_COORDS, default 4, number of packed coordinates (ball_x, ball_y, paddle_l_y, paddle_r_y order at default), legal range 1..8.
REQ-002 The module SHALL have parameter COORD_W, default 10, coordinate width in bits, legal range 9..16.
REQ-003 The module SHALL have parameter COORD_MAX, default 799, largest legal coordinate value, below 2**COORD_W.
REQ-004 The module SHALL have parameter NUM_SCORES, default 2, number of 8-bit score bytes, legal range 1..4.
REQ-005 The module SHALL have parameter STALE_FRAMES, default 60, number of commit-less frames before stale_o rises, legal range 1..255.
REQ-006 The module SHALL have localparam NUM_BYTES = 2*NUM_COORDS + NUM_SCORES.
REQ-007 The module SHALL have port sys_clk_i, input, width 1: the single clock, on which all state is rising-edge.
REQ-008 The module SHALL have port sys_rst_i, input, width 1: a synchronous, active-high reset.
REQ-009 The module SHALL have port data_ready_i, input, width 1: a one-cycle pulse meaning data_in holds a complete packet.
REQ-010 The module SHALL have port data_in, input, array [0:NUM_BYTES-1] of 8 bits: the packet bytes.
REQ-011 The module SHALL have port frame_start_i, input, width 1: a one-cycle pulse from VGA timing at the start of vertical blanking.
REQ-012 The module SHALL have port coord_o, output, array [0:NUM_COORDS-1] of COORD_W bits: the committed coordinates.
REQ-013 The module SHALL have port score_o, output, array [0:NUM_SCORES-1] of 8 bits: the committed scores.
REQ-014 The module SHALL have port frame_update_o, output, width 1: a one-cycle pulse on each commit.
REQ-015 The module SHALL have port pending_o, output, width 1: high when the shadow holds an uncommitted packet.
REQ-016 The module SHALL have port stale_o, output, width 1: high when no commit has occurred for STALE_FRAMES frames.
REQ-017 The module SHALL have port drop_cnt_o, output, width 8: a saturating count of overwritten uncommitted packets.
REQ-018 The module SHALL have port clamp_err_o, output, width 1: sticky, set when any coordinate was clamped.

Function
REQ-019 The decode SHALL be raw coord i = {data_in[2i+1], data_in[2i]}, taking the low COORD_W bits, so high-byte bits above COORD_W are ignored; score j = data_in[2*NUM_COORDS+j].
REQ-020 On data_ready_i at cycle N, the decoded packet SHALL be in the shadow registers and pending_o SHALL be high at N+1.
REQ-021 A raw coordinate greater than COORD_MAX SHALL be stored in the shadow as COORD_MAX, and clamp_err_o SHALL be set at N+1.
REQ-022 The state machine SHALL have two states: EMPTY (pending_o=0) and PENDING (pending_o=1).
REQ-023 In EMPTY, data_ready_i SHALL move the state to PENDING.
REQ-024 In PENDING, frame_start_i without data_ready_i SHALL move the state to EMPTY.
REQ-025 On frame_start_i at cycle M while in PENDING, coord_o and score_o SHALL show the shadow contents at M+1, and frame_update_o SHALL be high for exactly cycle M+1.
REQ-026 On frame_start_i while in EMPTY, outputs SHALL hold their values and frame_update_o SHALL stay low.
REQ-027 On data_ready_i while in PENDING without frame_start_i, the shadow SHALL be overwritten, the state SHALL stay PENDING, and drop_cnt_o SHALL increment, saturating at 255.
REQ-028 On simultaneous data_ready_i and frame_start_i in PENDING, the old shadow SHALL be committed, the new packet SHALL be captured, the state SHALL stay PENDING, and drop_cnt_o SHALL be unchanged.
REQ-029 On simultaneous data_ready_i and frame_start_i in EMPTY, no commit SHALL occur, the new packet SHALL be captured, and the state SHALL move to PENDING.
REQ-030 The stale counter SHALL be 8 bits, increment on each frame_start_i that causes no commit, saturate at STALE_FRAMES, and clear to 0 on each commit.
REQ-031 stale_o SHALL be high exactly when the stale counter equals STALE_FRAMES, and it SHALL drop in the same cycle frame_update_o rises.
REQ-032 Outputs SHALL change only at commit, so coord_o and score_o SHALL never show a mix of two packets.

Reset
REQ-033 While sys_rst_i is high at a rising edge, the next state SHALL be all zero: coord_o, score_o, shadow, drop_cnt_o, stale counter, frame_update_o, pending_o, stale_o and clamp_err_o all 0, with state EMPTY.
REQ-034 Reset SHALL take priority over data_ready_i and frame_start_i in the same cycle, so a packet pending at reset SHALL be discarded and never committed.

Verification
REQ-035 Basic commit (defaults): data_in={0x20,0x01,0x40,0x00,0x10,0x00,0x80,0x00,0x03,0x05} with data_ready_i, then frame_start_i 5 cycles later -> coord_o={288,64,16,128}, score_o={3,5}, one frame_update_o pulse, pending_o=0.
REQ-036 Clamp: ball_x bytes {0xFF,0x03} (1023) -> committed coord_o[0]=799, clamp_err_o=1, and it stays 1 after a later clean packet.
REQ-037 Overrun: three data_ready_i pulses with no frame_start_i, then frame_start_i -> drop_cnt_o=2 and the third packet is committed; 300 overruns -> drop_cnt_o=255.
REQ-038 Simultaneous events: packet A pending, then data_ready_i(B) and frame_start_i in the same cycle -> A visible with frame_update_o, pending_o=1; next frame_start_i -> B visible, drop_cnt_o=0.
REQ-039 Stale: STALE_FRAMES=3, four frame_start_i with no data -> stale_o rises after the third; a packet then frame_start_i -> stale_o=0 and frame_update_o=1 in the same cycle.
REQ-040 Reset mid-operation: packet pending, sys_rst_i high together with frame_start_i -> all outputs 0, no frame_update_o, and the next frame_start_i commits nothing.
